pmem: RTL

Parametrised two-read/one-write synchronous memory with registered read ports, per-port read-valid strobes and a hardware clear engine. It replaces fixed 8-bit, 256-entry data memories in the processor datapath. It fills every location with a known value after reset, or on request, so simulations and silicon never read undefined contents. Intended as the common data/scratch memory for later processor revisions.

---
 rtl/pmem_if.sv | 33 +++
 rtl/pmem.sv | 108 ++++++++++
 2 files changed

// File: rtl/pmem_if.sv
// Bus bundle for pmem: one write port, two registered read ports, clear request and busy status.
interface pmem_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 8
);
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en1;
   logic [AW-1:0]    rd_addr1;
   logic [WIDTH-1:0] rd_data1;
   logic             rd_valid1;
   logic             rd_en2;
   logic [AW-1:0]    rd_addr2;
   logic [WIDTH-1:0] rd_data2;
   logic             rd_valid2;
   logic             clr;
   logic             busy;

   modport master (
      output wr_en, wr_addr, wr_data,
      output rd_en1, rd_addr1, rd_en2, rd_addr2,
      output clr,
      input  rd_data1, rd_valid1, rd_data2, rd_valid2, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  rd_en1, rd_addr1, rd_en2, rd_addr2,
      input  clr,
      output rd_data1, rd_valid1, rd_data2, rd_valid2, busy
   );
endinterface

// File: rtl/pmem.sv
// Two-read/one-write synchronous memory with registered reads and a clear engine that fills
// every entry with CLR_VAL after reset or on clr. Define MEM_BYPASS_EN for write-first reads.
module pmem #(
   parameter int                  WIDTH   = 8,
   parameter int                  AW      = 8,
   parameter logic [WIDTH-1:0]    CLR_VAL = '0
) (
   input  logic   clk,
   input  logic   rst_n,
   pmem_if.slave  bus
);
   localparam int DEPTH = 2 ** AW;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic             busy;
   logic             wr_go, rd1_go, rd2_go;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [WIDTH-1:0] rd_data1_p1, rd_data2_p1;
   logic             vld1_p1, vld2_p1;

   // busy decodes the state register only, so no input reaches it combinationally
   assign busy   = (state_q == CLEAR);
   assign wr_go  = bus.wr_en  && !busy;
   assign rd1_go = bus.rd_en1 && !busy;
   assign rd2_go = bus.rd_en2 && !busy;

   function automatic logic [WIDTH-1:0] rd_word(input logic [AW-1:0] addr);
`ifdef MEM_BYPASS_EN
      if (wr_go && (bus.wr_addr == addr))
         return bus.wr_data;
      else
         return mem[addr];
`else
      return mem[addr];
`endif
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLEAR: begin
            if (ptr_q == {AW{1'b1}}) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d   = ptr_q + AW'(1);
            end
         end
         IDLE: begin
            if (bus.clr) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   // Array has no reset: contents become defined only through the clear engine
   always_ff @(posedge clk) begin
      if (busy)
         mem[ptr_q] <= CLR_VAL;
      else if (wr_go)
         mem[bus.wr_addr] <= bus.wr_data;
   end

   // Stage p1: registered read ports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data1_p1 <= '0;
         rd_data2_p1 <= '0;
         vld1_p1     <= 1'b0;
         vld2_p1     <= 1'b0;
      end else begin
         vld1_p1 <= rd1_go;
         vld2_p1 <= rd2_go;
         if (rd1_go)
            rd_data1_p1 <= rd_word(bus.rd_addr1);
         if (rd2_go)
            rd_data2_p1 <= rd_word(bus.rd_addr2);
      end
   end

   assign bus.rd_data1  = rd_data1_p1;
   assign bus.rd_valid1 = vld1_p1;
   assign bus.rd_data2  = rd_data2_p1;
   assign bus.rd_valid2 = vld2_p1;
   assign bus.busy      = busy;
endmodule
